mem_port: RTL and testbench
===========================

# mem_port

Memory access sequencer between the multicycle RISC-V datapath/controller and a variable-latency unified instruction/data memory. It turns the controller's level-held read and write requests into a registered req/ack transaction on the memory bus. It freezes the controller with `stall` until the access completes, then holds the returned word for the IR and data registers.

## Interface
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: data word width.
- `TIMEOUT`, 255: max cycles waiting for `m_ack`; used only with `MEM_PORT_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `adr` in ADDR_W: byte address from the AdrSrc mux.
- `wdata` in DATA_W: store data (rs2 register).
- `re` in 1: read request, held by the controller in IF and LWA.
- `we` in 1: write request (MemWrite), held in SW.
- `rdata` out DATA_W: last read word, registered.
- `stall` out 1: controller state-register hold.
- `err` out 1: sticky error flag.
- `m_req` out 1: bus request, registered.
- `m_we` out 1: bus write qualifier.
- `m_addr` out ADDR_W: bus address, registered.
- `m_wdata` out DATA_W: bus write data, registered.
- `m_ack` in 1: bus completion, one-cycle pulse.
- `m_rdata` in DATA_W: bus read data, valid with `m_ack`.

## Operation
- States: IDLE, REQ, DONE.
- IDLE:
  - `re|we` high and `adr[1:0]==0`: latch `adr`, `wdata`, `we` into `m_addr`/`m_wdata`/`m_we`; set `m_req`; go to REQ.
  - `re|we` high and `adr[1:0]!=0` (misaligned): no bus access; set `err`; `rdata` unchanged; go to DONE.
  - `re` and `we` both high: the write wins; `m_we=1`.
- REQ: hold `m_req` and all bus outputs stable until `m_ack`. On `m_ack`: clear `m_req`, load `rdata<=m_rdata` if the access is a read, go to DONE.
- DONE: single cycle; go to IDLE unconditionally. A still-asserted `re`/`we` is never relaunched here.
- `stall = (IDLE & (re|we)) | REQ`, combinational. Low in DONE so the controller advances on that edge.
- `m_ack` outside REQ is ignored.
- Writes never modify `rdata`.
- `err` stays set until reset.

## Timing
- Reset values: state IDLE, `rdata=0`, `err=0`, `m_req=0`, `m_we=0`, `m_addr=0`, `m_wdata=0`. `stall` follows its equation, so it is 0 unless `re|we` is high.
- Reset asserted mid-transaction drops `m_req` immediately, with no wait for the clock. A later stray `m_ack` is ignored.
- Request sampled at cycle 0 → `m_req` high from cycle 1. `m_ack` in cycle k (k≥1) → DONE in cycle k+1 with `rdata` valid → IDLE in cycle k+2.
- Minimum access is 3 cycles, with `stall` high in cycles 0..1. Each added bus wait cycle adds one stall cycle.
- Misaligned access: `stall` high in cycle 0 only; DONE in cycle 1.
- `rdata` stays stable from DONE until the next read's `m_ack`.
- Back-to-back requests: a new request sampled in the IDLE cycle after DONE starts a fresh transaction.

## Configuration
- `MEM_PORT_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter runs in REQ.
  - If `m_ack` has not arrived after `TIMEOUT` cycles in REQ: drop `m_req`, set `err`, and for a read load `rdata<=32'h00000013` (NOP); go to DONE.
  - `m_ack` arriving in the same cycle as expiry takes priority and is a normal completion.
- Undefined: no counter; REQ waits indefinitely; `err` reports misalignment only.

## Test plan
- Read, ack latency 1: `re=1`, `adr=0x10`, `m_rdata=0xDEADBEEF` → `m_req` high 1 cycle; `stall` high 2 cycles; `rdata=0xDEADBEEF` in DONE and held; `err=0`.
- Write, ack latency 4: `we=1`, `adr=0x20`, `wdata=0x12345678` → `m_we=1`, `m_addr=0x20`, `m_wdata=0x12345678` stable for 4 cycles; `stall` high 5 cycles; `rdata` unchanged.
- Misaligned: `re=1`, `adr=0x22` → `m_req` never asserts; `stall` high 1 cycle; `err=1` sticky.
- `re` held through DONE → exactly one bus transaction; stray `m_ack` while IDLE → no state change.
- Reset pulse during REQ → `m_req=0` immediately; all outputs at reset values; next request behaves normally.
- With `MEM_PORT_TIMEOUT_EN`, `TIMEOUT=8`, no ack on a read → `m_req` drops after 8 REQ cycles; `rdata=0x00000013`; `err=1`. Repeated with ack in the expiry cycle → normal read data; `err=0`.

Source files
------------

// File: rtl/mem_port.sv
// Memory access sequencer: turns level-held controller read/write requests into a
// registered req/ack bus transaction and stalls the controller until it completes.
// Optional bus timeout is enabled by defining MEM_PORT_TIMEOUT_EN.
module mem_port #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              we,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_m_req;
    logic              w_m_req_nxt;
    logic              r_m_we;
    logic              w_m_we_nxt;
    logic [ADDR_W-1:0] r_m_addr;
    logic [ADDR_W-1:0] w_m_addr_nxt;
    logic [DATA_W-1:0] r_m_wdata;
    logic [DATA_W-1:0] w_m_wdata_nxt;
    logic              w_access;
    logic              w_aligned;

    assign w_access  = re | we;
    assign w_aligned = (adr[1:0] == 2'b00);

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h0000_0013);

    logic [CNT_W-1:0] r_cnt;
    logic             w_expire;

    assign w_expire = (r_cnt == CNT_W'(TIMEOUT - 1));

    // Cycles spent waiting in REQ; cleared whenever the sequencer is elsewhere.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_state == REQ) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= {CNT_W{1'b0}};
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value logic for all registered outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_rdata_nxt   = r_rdata;
        w_err_nxt     = r_err;
        w_m_req_nxt   = r_m_req;
        w_m_we_nxt    = r_m_we;
        w_m_addr_nxt  = r_m_addr;
        w_m_wdata_nxt = r_m_wdata;
        case (r_state)
            IDLE: begin
                if (w_access && w_aligned) begin
                    // A simultaneous read and write resolves to the write.
                    w_m_addr_nxt  = adr;
                    w_m_wdata_nxt = wdata;
                    w_m_we_nxt    = we;
                    w_m_req_nxt   = 1'b1;
                    w_state_nxt   = REQ;
                end else if (w_access) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                if (m_ack) begin
                    w_m_req_nxt = 1'b0;
                    if (!r_m_we) begin
                        w_rdata_nxt = m_rdata;
                    end else begin
                        w_rdata_nxt = r_rdata;
                    end
                    w_state_nxt = DONE;
                end else begin
`ifdef MEM_PORT_TIMEOUT_EN
                    if (w_expire) begin
                        w_m_req_nxt = 1'b0;
                        w_err_nxt   = 1'b1;
                        if (!r_m_we) begin
                            w_rdata_nxt = NOP_WORD;
                        end else begin
                            w_rdata_nxt = r_rdata;
                        end
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = REQ;
                    end
`else
                    w_state_nxt = REQ;
`endif
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_m_req_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered output and bus-side state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata   <= {DATA_W{1'b0}};
            r_err     <= 1'b0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= {ADDR_W{1'b0}};
            r_m_wdata <= {DATA_W{1'b0}};
        end else begin
            r_rdata   <= w_rdata_nxt;
            r_err     <= w_err_nxt;
            r_m_req   <= w_m_req_nxt;
            r_m_we    <= w_m_we_nxt;
            r_m_addr  <= w_m_addr_nxt;
            r_m_wdata <= w_m_wdata_nxt;
        end
    end

    assign stall   = ((r_state == IDLE) && w_access) || (r_state == REQ);
    assign rdata   = r_rdata;
    assign err     = r_err;
    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;

endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port: directed and randomized accesses checked
// against a transaction-level model of the expected timeline.
module tb_mem_port;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        re;
    logic        we;
    logic [31:0] rdata;
    logic        stall;
    logic        err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    int          errors;
    int          checks;
    logic [31:0] exp_rdata;
    logic        exp_err;

    localparam int TO_CYCLES = 8;

    mem_port #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO_CYCLES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .adr    (adr),
        .wdata  (wdata),
        .re     (re),
        .we     (we),
        .rdata  (rdata),
        .stall  (stall),
        .err    (err),
        .m_req  (m_req),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_ack  (m_ack),
        .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m_req"}, {31'd0, m_req}, 32'd0);
        chk({tag, "_m_we"}, {31'd0, m_we}, 32'd0);
        chk({tag, "_m_addr"}, m_addr, 32'd0);
        chk({tag, "_m_wdata"}, m_wdata, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    // One controller access. lat = cycle of the ack pulse (1 = earliest);
    // noack = never acknowledge (timeout build only). hold keeps re/we high
    // across the DONE->IDLE edge.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input int lat, input bit noack,
                          input logic [31:0] ack_data, input bit hold);
        int n_req;
        logic [31:0] ack_word;
        @(negedge clk);
        re = rd; we = wr; adr = a; wdata = d; m_ack = 1'b0;
        #1;
        chk("stall_c0", {31'd0, stall}, 32'd1);
        if (a[1:0] != 2'b00) begin
            exp_err = 1'b1;
            @(negedge clk);
            chk("mis_m_req", {31'd0, m_req}, 32'd0);
        end else begin
            n_req = noack ? TO_CYCLES : lat;
            ack_word = 32'd0;
            for (int i = 1; i <= n_req; i++) begin
                @(negedge clk);
                chk("req_m_req", {31'd0, m_req}, 32'd1);
                chk("req_stall", {31'd0, stall}, 32'd1);
                chk("req_m_addr", m_addr, a);
                chk("req_m_we", {31'd0, m_we}, {31'd0, wr});
                chk("req_m_wdata", m_wdata, d);
                adr = $urandom; wdata = $urandom;
                if (i == n_req && !noack) begin
                    m_rdata = ack_data; ack_word = ack_data; m_ack = 1'b1;
                end else begin
                    m_rdata = $urandom; m_ack = 1'b0;
                end
            end
            if (noack) begin
                exp_err = 1'b1;
                if (!wr) exp_rdata = 32'h0000_0013;
            end else if (!wr) begin
                exp_rdata = ack_word;
            end
            @(negedge clk);
            m_ack = 1'b0; m_rdata = $urandom;
            chk("done_m_req", {31'd0, m_req}, 32'd0);
        end
        // DONE cycle
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_rdata", rdata, exp_rdata);
        chk("done_err", {31'd0, err}, {31'd0, exp_err});
        adr = a;
        if (!hold) begin
            re = 1'b0; we = 1'b0;
        end
        @(negedge clk);
        chk("idle_m_req", {31'd0, m_req}, 32'd0);
        chk("idle_stall", {31'd0, stall}, {31'd0, hold});
        chk("idle_rdata", rdata, exp_rdata);
        re = 1'b0; we = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        exp_rdata = 32'd0; exp_err = 1'b0;
        rst = 1'b0; re = 1'b0; we = 1'b0; adr = 32'd0; wdata = 32'd0;
        m_ack = 1'b0; m_rdata = 32'd0;
        #1;
        chk_reset_outputs("rst");
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Read, ack latency 1.
        access(1'b1, 1'b0, 32'h10, 32'h0, 1, 1'b0, 32'hDEADBEEF, 1'b0);
        // Write, ack latency 4: rdata must stay.
        access(1'b0, 1'b1, 32'h20, 32'h12345678, 4, 1'b0, 32'hCAFEF00D, 1'b0);
        // Read and write together: write wins.
        access(1'b1, 1'b1, 32'h24, 32'hA5A5A5A5, 2, 1'b0, 32'h0BADBEEF, 1'b0);
        // Read held through DONE: no relaunch.
        access(1'b1, 1'b0, 32'h30, 32'h0, 3, 1'b0, 32'h11223344, 1'b1);

        // Stray ack while idle is ignored.
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 32'hFFFF0000;
        @(negedge clk);
        m_ack = 1'b0;
        chk("stray_m_req", {31'd0, m_req}, 32'd0);
        chk("stray_rdata", rdata, exp_rdata);
        chk("stray_stall", {31'd0, stall}, 32'd0);

`ifdef MEM_PORT_TIMEOUT_EN
        // Ack in the expiry cycle is a normal completion.
        access(1'b1, 1'b0, 32'h50, 32'h0, TO_CYCLES, 1'b0, 32'h87654321, 1'b0);
        chk("to_ack_err", {31'd0, err}, 32'd0);
        // No ack: NOP word, err set.
        access(1'b1, 1'b0, 32'h54, 32'h0, 0, 1'b1, 32'h0, 1'b0);
        chk("to_nop_rdata", rdata, 32'h0000_0013);
        chk("to_err", {31'd0, err}, 32'd1);
`endif

        // Misaligned read: no bus access, sticky err.
        access(1'b1, 1'b0, 32'h22, 32'h0, 1, 1'b0, 32'h0, 1'b0);
        chk("mis_err_sticky", {31'd0, err}, 32'd1);

        // Reset during REQ drops m_req asynchronously.
        @(negedge clk);
        re = 1'b1; adr = 32'h40;
        @(negedge clk);
        chk("pre_rst_m_req", {31'd0, m_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        re = 1'b0;
        exp_rdata = 32'd0; exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_ack = 1'b1; m_rdata = 32'h99999999;
        @(negedge clk);
        m_ack = 1'b0;
        chk_reset_outputs("post_rst_ack");

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            bit rd, wr;
            logic [31:0] a;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            access(rd, wr, a, $urandom, int'($urandom_range(1, 6)), 1'b0,
                   $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
